matrix_scan_controller: RTL and testbench

- Row-scan sequencer for the 5x7 LED dot-matrix display.
- Walks row index 0..6 and presents `row_idx` plus a frame-stable symbol select to the per-row preset pattern logic.
- Registers the returned 5-bit column pattern and drives one active-low row at a time, with a blanking gap between rows to prevent ghosting.
- Symbol select changes only on frame boundaries, so a symbol is never drawn half old, half new.

---
 rtl/matrix_scan_controller.sv | 139 +++++++++++++
 tb/tb_matrix_scan_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_controller.sv
// matrix_scan_controller: row-scan sequencer for a 5x7 LED dot matrix (active-low rows, active-high columns).
// Latency: col_in is registered onto cols on the edge ending LOAD. Row period is BLANK_CYCLES+1+DIV_MAX+1 cycles.
// Backpressure: none. en is sampled only in IDLE and on the last SHOW cycle, so a row always completes its dwell.
//
// Ports:
//   clk, rst_n  - clock (rising edge), asynchronous active-low reset
//   en          - scan enable
//   sel_in      - requested symbol; latched into sel_frame only at frame start
//   col_in      - 5-bit pattern for (sel_frame, row_idx), combinational from preset logic
//   row_idx     - current row 0..6 to preset logic
//   sel_frame   - symbol held for the whole frame
//   rows_n      - one-hot active-low row drivers, 7'h7F = all off
//   cols        - registered column drivers
//   frame_done  - one-cycle pulse after row 6 completes
//
// Optional: define MATRIX_BLINK_EN to blank the columns on alternating runs of BLINK_FRAMES frames.
module matrix_scan_controller #(
  parameter int DIV_WIDTH    = 16,
  parameter int DIV_MAX      = 49999,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] sel_in,
  input  logic [4:0] col_in,
  output logic [2:0] row_idx,
  output logic [1:0] sel_frame,
  output logic [6:0] rows_n,
  output logic [4:0] cols,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, BLANK, LOAD, SHOW} state_t;

  localparam logic [6:0]           ALL_OFF    = 7'h7F;
  localparam logic [2:0]           LAST_ROW   = 3'd6;
  localparam logic [DIV_WIDTH-1:0] DWELL_LAST = DIV_WIDTH'(DIV_MAX);
  localparam logic [DIV_WIDTH-1:0] BLANK_LAST = DIV_WIDTH'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  // With no blanking the dark gap between rows is just the LOAD cycle.
  localparam state_t               ROW_START  = (BLANK_CYCLES == 0) ? LOAD : BLANK;

  state_t               state;
  logic [DIV_WIDTH-1:0] cnt;
  logic [4:0]           load_cols;

`ifdef MATRIX_BLINK_EN
  localparam int              FC_W       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FRAME_LAST = FC_W'((BLINK_FRAMES > 1) ? BLINK_FRAMES - 1 : 0);

  logic [FC_W-1:0] frame_cnt;
  logic            blink_on;
  logic            frame_end;

  // Same edge that raises frame_done, so the next frame's first LOAD already sees the new blink phase.
  assign frame_end = (state == SHOW) && (cnt == DWELL_LAST) && (row_idx == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_end) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end

  // Rows keep scanning while blanked so the frame timing never changes.
  assign load_cols = blink_on ? col_in : 5'd0;
`else
  assign load_cols = col_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row_idx    <= '0;
      sel_frame  <= '0;
      rows_n     <= ALL_OFF;
      cols       <= '0;
      frame_done <= 1'b0;
      cnt        <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          rows_n <= ALL_OFF;
          cols   <= '0;
          if (en) begin
            sel_frame <= sel_in;
            row_idx   <= '0;
            cnt       <= '0;
            state     <= ROW_START;
          end
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt   <= '0;
            state <= LOAD;
          end else begin
            cnt <= cnt + DIV_WIDTH'(1);
          end
        end
        LOAD: begin
          // Row and columns switch on together so no stale pattern is ever lit.
          cols   <= load_cols;
          rows_n <= ~(7'b1 << row_idx);
          cnt    <= '0;
          state  <= SHOW;
        end
        SHOW: begin
          if (cnt == DWELL_LAST) begin
            rows_n <= ALL_OFF;
            cols   <= '0;
            cnt    <= '0;
            if (row_idx == LAST_ROW) begin
              // Frame boundary: only place a new symbol is picked up.
              row_idx    <= '0;
              sel_frame  <= sel_in;
              frame_done <= 1'b1;
            end else begin
              row_idx <= row_idx + 3'd1;
            end
            state <= en ? ROW_START : IDLE;
          end else begin
            cnt <= cnt + DIV_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scan_controller.sv
module tb_matrix_scan_controller;

  localparam int DIV_MAX      = 3;
  localparam int BLANK_CYCLES = 1;
  localparam int BLINK_FRAMES = 2;
`ifdef MATRIX_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  // Active-low one-hot row pattern for rows 0..6.
  localparam logic [6:0] ROW_PAT [7] = '{7'h7E, 7'h7D, 7'h7B, 7'h77, 7'h6F, 7'h5F, 7'h3F};

  typedef struct {
    logic [6:0] rows;
    logic [4:0] cols;
    int         gap;   // dark cycles before this row, -1 = not checked (after IDLE)
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n, en;
  logic [1:0] sel_in;
  logic [4:0] col_in;
  logic [2:0] row_idx;
  logic [1:0] sel_frame;
  logic [6:0] rows_n;
  logic [4:0] cols;
  logic       frame_done;

  logic       rst_n_b, en_b;
  logic [1:0] sel_in_b;
  logic [4:0] col_in_b;
  logic [2:0] row_idx_b;
  logic [1:0] sel_frame_b;
  logic [6:0] rows_n_b;
  logic [4:0] cols_b;
  logic       frame_done_b;

  int  checks   = 0;
  int  failures = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  // Preset-logic stub: distinct, never-zero pattern for every (symbol, row).
  function automatic logic [4:0] stub(input logic [1:0] s, input logic [2:0] r);
    return {s, r} + 5'd1;
  endfunction

  assign col_in   = stub(sel_frame, row_idx);
  assign col_in_b = stub(sel_frame_b, row_idx_b);

  matrix_scan_controller #(
    .DIV_WIDTH(16), .DIV_MAX(DIV_MAX), .BLANK_CYCLES(BLANK_CYCLES), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sel_in(sel_in), .col_in(col_in),
    .row_idx(row_idx), .sel_frame(sel_frame), .rows_n(rows_n), .cols(cols), .frame_done(frame_done)
  );

  matrix_scan_controller #(
    .DIV_WIDTH(16), .DIV_MAX(DIV_MAX), .BLANK_CYCLES(0), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .en(en_b), .sel_in(sel_in_b), .col_in(col_in_b),
    .row_idx(row_idx_b), .sel_frame(sel_frame_b), .rows_n(rows_n_b), .cols(cols_b), .frame_done(frame_done_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Queue the rows a frame should present. blank_frame marks a blink-off frame.
  task automatic push_frame(input logic [1:0] s, input bit blank_frame, input int first_gap, input int nrows);
    ev_t e;
    for (int r = 0; r < nrows; r++) begin
      e.rows = ROW_PAT[r];
      e.cols = (BLINK && blank_frame) ? 5'd0 : stub(s, 3'(r));
      e.gap  = (r == 0) ? first_gap : BLANK_CYCLES + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_rows(input logic [6:0] v, input int budget);
    int n = 0;
    while (rows_n !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_rows", rows_n, v);
  endtask

  task automatic wait_fd(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < budget);
    chk("wait_frame_done", frame_done, 1);
  endtask

  // Monitor: pops an expected row whenever a new row lights, and checks dwell, gaps, frame_done.
  initial begin : monitor
    logic [6:0] prev_rows, cur_rows;
    logic [4:0] cur_cols;
    bit         in_row;
    int         dwell, dark;
    ev_t        e;
    prev_rows = 7'h7F;
    cur_rows  = 7'h7F;
    cur_cols  = 5'd0;
    in_row    = 1'b0;
    dwell     = 0;
    dark      = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rows = 7'h7F;
        in_row    = 1'b0;
        dark      = 0;
      end else begin
        chk("rows_onehot", ($countones(~rows_n) <= 1), 1);
        chk("frame_done_pulse", frame_done, (prev_rows == 7'h3F) && (rows_n == 7'h7F));
        if (rows_n != 7'h7F) begin
          if (!in_row) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_row", rows_n, 7'h7F);
            end else begin
              e = exp_q.pop_front();
              chk("row_rows", rows_n, e.rows);
              chk("row_cols", cols, e.cols);
              if (e.gap >= 0) chk("row_gap", dark, e.gap);
            end
            in_row   = 1'b1;
            dwell    = 1;
            cur_rows = rows_n;
            cur_cols = cols;
          end else begin
            dwell++;
            chk("row_hold", {rows_n, cols}, {cur_rows, cur_cols});
          end
        end else begin
          chk("dark_cols", cols, 0);
          if (in_row) begin
            chk("row_dwell", dwell, DIV_MAX + 1);
            in_row = 1'b0;
            dark   = 1;
          end else begin
            dark++;
          end
        end
        prev_rows = rows_n;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    fork
      begin : thread_a
        int n;
        rst_n = 1'b0; en = 1'b0; sel_in = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_rows_n", rows_n, 7'h7F);
        chk("rst_cols", cols, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_row_idx", row_idx, 0);
        chk("rst_sel_frame", sel_frame, 0);

        push_frame(2'd2, 1'b0, -1, 3);
        rst_n = 1'b1; en = 1'b1; sel_in = 2'd2;
        wait_rows(7'h7B, 60);
        // Asynchronous reset mid-SHOW, checked before the next rising edge.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_rows_n", rows_n, 7'h7F);
        chk("async_rst_cols", cols, 0);
        @(negedge clk);
        @(negedge clk);
        push_frame(2'd2, 1'b0, -1, 7);   // frame 1
        push_frame(2'd1, 1'b0, 2, 7);    // frame 2 picks up sel change
        rst_n = 1'b1;
        // IDLE cycle, BLANK, LOAD, then row 0.
        n = 0;
        while (rows_n !== 7'h7E && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("restart_latency", n, 3);

        wait_rows(7'h77, 60);
        sel_in = 2'd1;
        wait_fd(60);
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (frame_done !== 1'b1 && n < 100);
        chk("frame_period", n, 42);

        push_frame(2'd1, 1'b1, 2, 7);    // frame 3 (blink off)
        push_frame(2'd1, 1'b1, 2, 5);    // frame 4 stops after row 4
        wait_fd(60);
        wait_rows(7'h6F, 60);
        en = 1'b0;
        repeat (20) @(negedge clk);
        chk("en_drop_rows_n", rows_n, 7'h7F);
        chk("en_drop_row_idx", row_idx, 5);
        chk("en_drop_sel_frame", sel_frame, 1);

        sel_in = 2'd3;
        push_frame(2'd3, 1'b1, -1, 7);   // restart: still blink off
        push_frame(2'd3, 1'b0, 2, 7);    // blink back on
        en = 1'b1;
        wait_fd(100);
        wait_rows(7'h3F, 60);
        sel_in = 2'd0;
        en = 1'b0;
        wait_fd(20);
        repeat (10) @(negedge clk);
        chk("final_rows_n", rows_n, 7'h7F);
        chk("final_cols", cols, 0);
        chk("final_row_idx", row_idx, 0);
        chk("final_sel_frame", sel_frame, 0);
        chk("queue_empty", exp_q.size(), 0);
      end
      begin : thread_b
        int n;
        int p;
        logic [6:0] er;
        logic [4:0] ec;
        rst_n_b = 1'b0; en_b = 1'b0; sel_in_b = 2'd1;
        repeat (3) @(negedge clk);
        rst_n_b = 1'b1; en_b = 1'b1;
        n = 0;
        while (rows_n_b !== 7'h7E && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("b_start", rows_n_b, 7'h7E);
        // Period 5: four SHOW cycles then a single dark LOAD cycle.
        for (int k = 0; k < 36; k++) begin
          p  = k % 35;
          er = ((p % 5) < 4) ? ROW_PAT[p / 5] : 7'h7F;
          ec = ((p % 5) < 4) ? stub(2'd1, 3'(p / 5)) : 5'd0;
          chk("b_rows_n", rows_n_b, er);
          chk("b_cols", cols_b, ec);
          chk("b_frame_done", frame_done_b, (k == 34));
          chk("b_onehot", ($countones(~rows_n_b) <= 1), 1);
          @(negedge clk);
        end
        en_b = 1'b0;
      end
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
